uart_tx_core: RTL and testbench

//  Parametrised UART transmitter and the successor to the fixed 8N1 TX path.
//  - Serialises DATA_W-bit words, LSB first, on tx_out.
//  - Runtime-selectable parity: none, even or odd.
//  - Runtime-selectable 1 or 2 stop bits.
//  - Internal bit-period counter.
//  - valid/ready handshake toward the host/FIFO side; drives the UART pin directly.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_core.sv | 154 +++++++++++++++
 tb/tb_uart_tx_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode codes and default
// frame parameters, shared by the TX core and the future RX core.
package uart_pkg;

    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 16;

    // parity_mode encodings; 2'b11 is treated as none
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and flags the last cycle of every
// CLKS_PER_BIT-cycle bit period.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   clear        synchronous clear; holds the count at 0
//   bit_end      high on the last cycle of a bit period (count == CLKS_PER_BIT-1)
//   near_end_c   high on the cycle before bit_end (count == CLKS_PER_BIT-2)
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic near_end_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    // Both flags decode the count register only.
    assign bit_end    = (count == CNT_W'(CLKS_PER_BIT - 1));
    assign near_end_c = (count == CNT_W'(CLKS_PER_BIT - 2));

    // Free-running period counter, wrapping at the end of each bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: DATA_W data bits LSB first, optional
// even/odd parity, one or two stop bits, valid/ready host handshake.
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   tx_valid      host presents a word
//   tx_ready      core accepts a word this cycle (high only in IDLE)
//   tx_data       word to send, latched at accept
//   parity_mode   00 none, 01 even, 10 odd, 11 none; latched at accept
//   stop2         0: one stop bit, 1: two stop bits; latched at accept
//   tx_out        serial line, idle high
//   busy          frame in progress
//   tx_done       one-cycle pulse on the last clk of the final stop bit
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

    uart_state_e       state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]  bit_idx, bit_idx_next;
    logic              par_en, par_en_next;
    logic              par_bit, par_bit_next;
    logic              stop2_q, stop2_next;
    logic              tx_out_next;
    logic              tx_done_next;
    logic              timer_clear;
    logic              bit_end;
    logic              near_end_c;

    // Bit timer is held at zero in IDLE so START begins a full period.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (timer_clear),
        .bit_end    (bit_end),
        .near_end_c (near_end_c)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            bit_idx  <= bit_idx_next;
            par_en   <= par_en_next;
            par_bit  <= par_bit_next;
            stop2_q  <= stop2_next;
            tx_out   <= tx_out_next;
            tx_ready <= (state_next == IDLE);
            busy     <= (state_next != IDLE);
            tx_done  <= tx_done_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        par_en_next  = par_en;
        par_bit_next = par_bit;
        stop2_next   = stop2_q;
        timer_clear  = 1'b0;
        tx_done_next = 1'b0;
        tx_out_next  = 1'b1;

        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (tx_valid) begin
                    state_next   = START;
                    shreg_next   = tx_data;
                    bit_idx_next = '0;
                    par_en_next  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    par_bit_next = (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
                    stop2_next   = stop2;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_next = '0;
                        state_next   = par_en ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // bit_idx counts stop bits here; the last one ends the frame.
                if (bit_idx == IDX_W'(stop2_q)) begin
                    tx_done_next = near_end_c;
                    if (bit_end) begin
                        state_next = IDLE;
                    end
                end else if (bit_end) begin
                    bit_idx_next = bit_idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Line level for the cycle following this edge.
        case (state_next)
            START:   tx_out_next = 1'b0;
            DATA:    tx_out_next = shreg_next[0];
            PARITY:  tx_out_next = par_bit_next;
            default: tx_out_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: lane 0 is DATA_W=8/CLKS_PER_BIT=4,
// lane 1 is DATA_W=5/CLKS_PER_BIT=2. Expected frames are queued when a word
// is driven and checked cycle by cycle once the core accepts it.
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int unsigned CPB_A = 4;
    localparam int unsigned DW_A  = 8;
    localparam int unsigned CPB_B = 2;
    localparam int unsigned DW_B  = 5;

    typedef struct {
        logic [15:0] bits;
        int unsigned nbits;
        int unsigned cpb;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid_w [2];
    logic       tx_ready_w [2];
    logic [1:0] pm_w       [2];
    logic       st2_w      [2];
    logic       tx_out_w   [2];
    logic       busy_w     [2];
    logic       tx_done_w  [2];
    logic [7:0] data_a;
    logic [4:0] data_b;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cycle_n  = 0;

    frame_t      q0 [$];
    frame_t      q1 [$];
    frame_t      cur      [2];
    logic        in_frame [2] = '{1'b0, 1'b0};
    logic        gap_chk  [2] = '{1'b0, 1'b0};
    int unsigned cyc      [2] = '{0, 0};
    int unsigned acc_cnt  [2] = '{0, 0};
    int unsigned last_acc [2] = '{0, 0};
    int unsigned last_fl  [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_W(DW_A), .CLKS_PER_BIT(CPB_A)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid_w[0]),
        .tx_ready    (tx_ready_w[0]),
        .tx_data     (data_a),
        .parity_mode (pm_w[0]),
        .stop2       (st2_w[0]),
        .tx_out      (tx_out_w[0]),
        .busy        (busy_w[0]),
        .tx_done     (tx_done_w[0])
    );

    uart_tx_core #(.DATA_W(DW_B), .CLKS_PER_BIT(CPB_B)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .tx_valid    (tx_valid_w[1]),
        .tx_ready    (tx_ready_w[1]),
        .tx_data     (data_b),
        .parity_mode (pm_w[1]),
        .stop2       (st2_w[1]),
        .tx_out      (tx_out_w[1]),
        .busy        (busy_w[1]),
        .tx_done     (tx_done_w[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    function automatic frame_t make_frame(input logic [8:0] d, input int unsigned dw,
                                          input logic [1:0] pm, input logic s2,
                                          input int unsigned cpb);
        frame_t      f;
        int unsigned n;
        logic        p;
        f.bits = '0;
        f.cpb  = cpb;
        n      = 0;
        p      = 1'b0;
        f.bits[4'(n)] = 1'b0;
        n++;
        for (int i = 0; i < int'(dw); i++) begin
            f.bits[4'(n)] = d[4'(i)];
            p = p ^ d[4'(i)];
            n++;
        end
        if (pm == PAR_EVEN) begin
            f.bits[4'(n)] = p;
            n++;
        end else if (pm == PAR_ODD) begin
            f.bits[4'(n)] = ~p;
            n++;
        end
        f.bits[4'(n)] = 1'b1;
        n++;
        if (s2) begin
            f.bits[4'(n)] = 1'b1;
            n++;
        end
        f.nbits = n;
        return f;
    endfunction

    // Monitor: track each lane's frame from the accept edge onward.
    always @(negedge clk) begin
        int unsigned fl;
        int unsigned bi;
        int unsigned qs;
        cycle_n++;
        for (int l = 0; l < 2; l++) begin
            if (!reset) begin
                in_frame[l] = 1'b0;
            end else begin
                if (in_frame[l]) begin
                    fl = cur[l].nbits * cur[l].cpb;
                    cyc[l]++;
                    if (cyc[l] <= fl) begin
                        bi = (cyc[l] - 1) / cur[l].cpb;
                        check("line", 32'(tx_out_w[l]), 32'(cur[l].bits[4'(bi)]));
                        check("done", 32'(tx_done_w[l]), 32'(cyc[l] == fl));
                        check("busy", 32'(busy_w[l]), 32'd1);
                        check("ready", 32'(tx_ready_w[l]), 32'd0);
                    end else begin
                        check("ready_end", 32'(tx_ready_w[l]), 32'd1);
                        check("busy_end", 32'(busy_w[l]), 32'd0);
                        check("done_end", 32'(tx_done_w[l]), 32'd0);
                        check("line_end", 32'(tx_out_w[l]), 32'd1);
                        in_frame[l] = 1'b0;
                        last_fl[l]  = fl;
                    end
                end else begin
                    check("idle_line", 32'(tx_out_w[l]), 32'd1);
                    check("idle_busy", 32'(busy_w[l]), 32'd0);
                    check("idle_done", 32'(tx_done_w[l]), 32'd0);
                end
                if (!in_frame[l] && tx_valid_w[l] && tx_ready_w[l]) begin
                    qs = (l == 0) ? 32'(q0.size()) : 32'(q1.size());
                    check("sb_nonempty", 32'(qs != 0), 32'd1);
                    if (qs != 0) begin
                        cur[l] = (l == 0) ? q0.pop_front() : q1.pop_front();
                        if (gap_chk[l]) begin
                            check("accept_gap", cycle_n - last_acc[l], last_fl[l] + 1);
                        end
                        last_acc[l] = cycle_n;
                        acc_cnt[l]++;
                        in_frame[l] = 1'b1;
                        cyc[l]      = 0;
                    end
                end
            end
        end
    end

    task automatic send(input int l, input logic [8:0] d, input logic [1:0] pm, input logic s2);
        if (l == 0) begin
            data_a = d[7:0];
            q0.push_back(make_frame(d, DW_A, pm, s2, CPB_A));
        end else begin
            data_b = d[4:0];
            q1.push_back(make_frame(d, DW_B, pm, s2, CPB_B));
        end
        pm_w[l]       = pm;
        st2_w[l]      = s2;
        tx_valid_w[l] = 1'b1;
    endtask

    task automatic wait_accept(input int l, input int unsigned prev);
        int unsigned n = 0;
        while (acc_cnt[l] == prev && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'd1);
        #1;
    endtask

    task automatic wait_idle(input int l);
        int unsigned n = 0;
        while ((in_frame[l] || ((l == 0) ? q0.size() : q1.size()) != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 400), 32'd1);
        #1;
    endtask

    task automatic tx_word(input int l, input logic [8:0] d, input logic [1:0] pm, input logic s2);
        int unsigned prev;
        prev = acc_cnt[l];
        send(l, d, pm, s2);
        wait_accept(l, prev);
        tx_valid_w[l] = 1'b0;
        wait_idle(l);
    endtask

    initial begin
        int unsigned prev;
        reset = 1'b0;
        for (int l = 0; l < 2; l++) begin
            tx_valid_w[l] = 1'b0;
            pm_w[l]       = PAR_NONE;
            st2_w[l]      = 1'b0;
        end
        data_a = '0;
        data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            check("rst_line", 32'(tx_out_w[l]), 32'd1);
            check("rst_ready", 32'(tx_ready_w[l]), 32'd1);
            check("rst_busy", 32'(busy_w[l]), 32'd0);
            check("rst_done", 32'(tx_done_w[l]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Abort mid-DATA while the line is low, then send a clean frame.
        prev = acc_cnt[0];
        send(0, 9'h0A5, PAR_EVEN, 1'b0);
        wait_accept(0, prev);
        tx_valid_w[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_line", 32'(tx_out_w[0]), 32'd1);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_ready", 32'(tx_ready_w[0]), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tx_word(0, 9'h03C, PAR_NONE, 1'b0);

        // Parity and stop-bit variants.
        tx_word(0, 9'h0A5, PAR_EVEN, 1'b0);
        tx_word(0, 9'h0A5, PAR_ODD, 1'b0);
        tx_word(0, 9'h007, PAR_EVEN, 1'b0);
        tx_word(0, 9'h0A5, 2'b11, 1'b0);
        tx_word(0, 9'h05A, PAR_NONE, 1'b1);

        // tx_valid held across three words; inputs disturbed while busy.
        prev = acc_cnt[0];
        send(0, 9'h011, PAR_EVEN, 1'b0);
        wait_accept(0, prev);
        gap_chk[0] = 1'b1;
        data_a = 8'hFF;
        pm_w[0] = 2'b11;
        st2_w[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        prev = acc_cnt[0];
        send(0, 9'h022, PAR_ODD, 1'b1);
        wait_accept(0, prev);
        data_a = 8'h00;
        pm_w[0] = PAR_EVEN;
        st2_w[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        prev = acc_cnt[0];
        send(0, 9'h033, 2'b11, 1'b0);
        wait_accept(0, prev);
        tx_valid_w[0] = 1'b0;
        wait_idle(0);
        gap_chk[0] = 1'b0;

        // Narrow configuration.
        tx_word(1, 9'h01F, PAR_EVEN, 1'b0);
        tx_word(1, 9'h00A, PAR_ODD, 1'b1);

        // A few random words on the wide lane.
        for (int k = 0; k < 6; k++) begin
            tx_word(0, 9'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
